// File: rtl/board_pixel_pipeline_if.sv
// Board-RAM read port between the pixel pipeline and the board RAM.
//   ram_rd_en  read strobe, one per in-board pixel
//   ram_x      cell column being read
//   ram_y      cell row being read
//   ram_color  cell colour {R,G,B}, valid one cycle after ram_rd_en; 0 = empty
// master: pixel pipeline side.  slave: RAM side.
interface board_pixel_pipeline_if #(
  parameter int CW = 8
);
  logic            ram_rd_en;
  logic [4:0]      ram_x;
  logic [4:0]      ram_y;
  logic [3*CW-1:0] ram_color;

  modport master (output ram_rd_en, ram_x, ram_y, input ram_color);
  modport slave  (input ram_rd_en, ram_x, ram_y, output ram_color);
endinterface

// File: rtl/board_pixel_pipeline.sv
// Board pixel pipeline: turns the VGA raster position into board cell
// coordinates with running counters, reads the board RAM and composes the
// final {R,G,B} pixel over a fixed 3-clock pipeline. Also runs the
// line-clear flash animation (white blink of the rows being destroyed).
//
// Ports:
//   clk, reset              pixel clock, synchronous active-high reset
//   frame_start             one-cycle pulse per frame (flash timing)
//   blank_n, row, column    raster position + active-video flag
//   q                       game FSM state
//   clear_mask              rows being destroyed, bit 0 = top row
//   piece_cells/piece_color falling piece, four {cx,cy} cells, square 0 in LSBs
//   ram                     board-RAM read port (master)
//   red, green, blue        pixel outputs, 0 during blanking
//   blank_n_o               blank_n delayed to match the pixel outputs
//   flash_done              one-cycle pulse when the flash animation completes
module board_pixel_pipeline #(
  parameter int CW           = 8,
  parameter int CELL         = 20,
  parameter int COLS         = 10,
  parameter int ROWS         = 20,
  parameter int BOARD_X      = 220,
  parameter int BOARD_Y      = 40,
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_BLINKS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                blank_n,
  input  logic [8:0]          row,
  input  logic [9:0]          column,
  input  logic [2:0]          q,
  input  logic [ROWS-1:0]     clear_mask,
  input  logic [39:0]         piece_cells,
  input  logic [3*CW-1:0]     piece_color,
  board_pixel_pipeline_if.master ram,
  output logic [CW-1:0]       red,
  output logic [CW-1:0]       green,
  output logic [CW-1:0]       blue,
  output logic                blank_n_o,
  output logic                flash_done
);

  localparam int STAGES = 3;
  localparam logic [2:0] Q_FALLING = 3'd3;
  localparam logic [2:0] Q_DISTROY = 3'd4;

  // Palette entries are defined as 8-bit values; narrower or wider channels
  // take them MSB-aligned.
  function automatic logic [CW-1:0] pal(input logic [7:0] v);
    logic [CW+7:0] w;
    w = {v, {CW{1'b0}}};
    return w[CW+7 -: CW];
  endfunction

  localparam logic [3*CW-1:0] ROSE  = {pal(8'd255), pal(8'd204), pal(8'd229)};
  localparam logic [3*CW-1:0] ROSE2 = {pal(8'd255), pal(8'd190), pal(8'd240)};
  localparam logic [3*CW-1:0] DGREY = {pal(8'd96),  pal(8'd96),  pal(8'd96)};

  localparam int OW = $clog2(CELL);
  localparam logic [OW-1:0] OFF_LAST = OW'(CELL - 1);
  localparam logic [10:0] X_LO = 11'(BOARD_X);
  localparam logic [10:0] X_HI = 11'(BOARD_X + COLS * CELL);
  localparam logic [9:0]  Y_LO = 10'(BOARD_Y);
  localparam logic [9:0]  Y_HI = 10'(BOARD_Y + ROWS * CELL);

  // ---------------------------------------------------------------- stage 0
  // The *_q registers hold the position of the previous pixel; the comb
  // values below are the position of the pixel on the inputs right now.
  logic [OW-1:0] col_off_q, col_off, row_off_q, row_off;
  logic [4:0]    cell_x_q, cell_x, cell_y_q, cell_y;
  logic          in_board;

  always_comb begin
    col_off = col_off_q + OW'(1);
    cell_x  = cell_x_q;
    if (column == 10'(BOARD_X)) begin
      col_off = '0;
      cell_x  = '0;
    end else if (col_off_q == OFF_LAST) begin
      col_off = '0;
      cell_x  = cell_x_q + 5'd1;
    end

    // Row position advances once per line, at column 0.
    row_off = row_off_q;
    cell_y  = cell_y_q;
    if (column == '0) begin
      if (row == 9'(BOARD_Y)) begin
        row_off = '0;
        cell_y  = '0;
      end else if (row_off_q == OFF_LAST) begin
        row_off = '0;
        cell_y  = cell_y_q + 5'd1;
      end else begin
        row_off = row_off_q + OW'(1);
      end
    end

    in_board = ({1'b0, column} >= X_LO) && ({1'b0, column} < X_HI) &&
               ({1'b0, row} >= Y_LO) && ({1'b0, row} < Y_HI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_off_q <= '0;
      cell_x_q  <= '0;
      row_off_q <= '0;
      cell_y_q  <= '0;
    end else begin
      col_off_q <= col_off;
      cell_x_q  <= cell_x;
      row_off_q <= row_off;
      cell_y_q  <= cell_y;
    end
  end

  // ------------------------------------------------------- stages 1 and 2
  // vld_pipe carries blank_n alongside the pixel: [0] stage 1, [1] stage 2,
  // [2] output stage.
  logic [STAGES-1:0] vld_pipe;
  logic              s1_in_board, s1_col0, s2_in_board, s2_col0;
  logic [4:0]        s1_cx, s1_cy, s2_cx, s2_cy;
  logic [4:0]        ram_x_q, ram_y_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe    <= '0;
      s1_in_board <= 1'b0;
      s1_col0     <= 1'b0;
      s1_cx       <= '0;
      s1_cy       <= '0;
      s2_in_board <= 1'b0;
      s2_col0     <= 1'b0;
      s2_cx       <= '0;
      s2_cy       <= '0;
      ram_x_q     <= '0;
      ram_y_q     <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-2:0], blank_n};
      s1_in_board <= in_board;
      s1_col0     <= (col_off == '0);
      s1_cx       <= cell_x;
      s1_cy       <= cell_y;
      // RAM address only moves for board pixels so the bus stays quiet
      // across the border and blanking.
      if (in_board) begin
        ram_x_q <= cell_x;
        ram_y_q <= cell_y;
      end
      s2_in_board <= s1_in_board;
      s2_col0     <= s1_col0;
      s2_cx       <= s1_cx;
      s2_cy       <= s1_cy;
    end
  end

  assign ram.ram_rd_en = s1_in_board;
  assign ram.ram_x     = ram_x_q;
  assign ram.ram_y     = ram_y_q;

  // ---------------------------------------------------------- flash FSM
  localparam logic [1:0] F_IDLE = 2'd0;
  localparam logic [1:0] F_ON   = 2'd1;
  localparam logic [1:0] F_OFF  = 2'd2;
  localparam logic [1:0] F_DONE = 2'd3;

  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int BW = $clog2(FLASH_BLINKS + 1);

  logic [1:0]    fstate;
  logic [FW-1:0] frame_cnt;
  logic [BW-1:0] blink_cnt;
  logic          frame_last, blink_last, flash_on;

  assign frame_last = (frame_cnt == FW'(FLASH_FRAMES - 1));
  assign blink_last = (blink_cnt == BW'(FLASH_BLINKS - 1));
  assign flash_on   = (fstate == F_ON);

  always_ff @(posedge clk) begin
    if (reset) begin
      fstate     <= F_IDLE;
      frame_cnt  <= '0;
      blink_cnt  <= '0;
      flash_done <= 1'b0;
    end else begin
      flash_done <= 1'b0;
      // Leaving DISTROY_LINE aborts from any state and beats a coincident
      // frame_start.
      if (q != Q_DISTROY) begin
        fstate    <= F_IDLE;
        frame_cnt <= '0;
        blink_cnt <= '0;
      end else begin
        case (fstate)
          F_IDLE: begin
            fstate    <= F_ON;
            frame_cnt <= '0;
            blink_cnt <= '0;
          end
          F_ON: if (frame_start) begin
            if (frame_last) begin
              fstate    <= F_OFF;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end
          F_OFF: if (frame_start) begin
            if (frame_last) begin
              frame_cnt <= '0;
              if (blink_last) begin
                fstate     <= F_DONE;
                flash_done <= 1'b1;
              end else begin
                fstate    <= F_ON;
                blink_cnt <= blink_cnt + BW'(1);
              end
            end else begin
              frame_cnt <= frame_cnt + FW'(1);
            end
          end
          default: fstate <= F_DONE;  // DONE waits for q to move on
        endcase
      end
    end
  end

  // ------------------------------------------------- compose + stage 3
  logic            piece_hit, row_clr;
  logic [31:0]     mask_ext;
  logic [3*CW-1:0] pix;

  always_comb begin
    piece_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (piece_cells[10*i+5 +: 5] == s2_cx && piece_cells[10*i +: 5] == s2_cy)
        piece_hit = 1'b1;
    end
    mask_ext = 32'(clear_mask);
    row_clr  = mask_ext[s2_cy];

    pix = DGREY;
    if (s2_in_board) begin
      if (q == Q_FALLING && piece_hit)
        pix = piece_color;
      else if (q == Q_DISTROY && row_clr && flash_on)
        pix = '1;
      else if (ram.ram_color != '0)
        pix = ram.ram_color;
      else if (s2_col0 && s2_cx != '0)
        pix = ROSE2;
      else
        pix = ROSE;
    end
    if (!vld_pipe[1])
      pix = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      blank_n_o <= 1'b0;
    end else begin
      {red, green, blue} <= pix;
      blank_n_o          <= vld_pipe[1];
    end
  end

endmodule

// File: doc/board_pixel_pipeline.md
Name: board_pixel_pipeline

Overview:
- Registered, parametrised successor to the combinational board colour generator.
- Converts the VGA raster position into board cell coordinates with counters instead of comparators. Issues a synchronous board-RAM read and composes the final pixel over a fixed 3-cycle pipeline.
- Adds a timed line-clear flash animation and generalises board geometry and channel width.
- Sits between the VGA timing generator and the RGB DAC pins; the board RAM and game FSM feed it.

Parameters:
- CW, 8, bits per colour channel; pixel word is 3*CW, ordered {R,G,B}.
- CELL, 20, cell edge in pixels (≥4).
- COLS, 10, board columns.
- ROWS, 20, board rows.
- BOARD_X, 220, first board pixel column.
- BOARD_Y, 40, first board pixel row.
- FLASH_FRAMES, 8, frames per flash half-period.
- FLASH_BLINKS, 3, full on/off blinks before completion.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse per frame.
- blank_n  in  1  active-video flag aligned with row/column.
- row  in  9  raster row.
- column  in  10  raster column.
- q  in  3  game state (COUNTING=1, FALLING=3, DISTROY_LINE=4, LINES_DOWN=6).
- clear_mask  in  ROWS  board rows being destroyed; bit 0 is the top row.
- piece_cells  in  4*(5+5)  four falling-piece cells, each {cx[4:0], cy[4:0]}; square 0 in the LSBs.
- piece_color  in  3*CW  falling-piece colour.
- ram_rd_en  out  1  board-RAM read strobe.
- ram_x  out  5  RAM cell column.
- ram_y  out  5  RAM cell row.
- ram_color  in  3*CW  RAM data, valid one cycle after ram_rd_en; 0 means empty.
- red, green, blue  out  CW each  pixel outputs.
- blank_n_o  out  1  blank_n delayed by 3.
- flash_done  out  1  one-cycle pulse when the flash animation ends.

Behaviour:
- Reset: all pipeline registers, outputs and counters are 0; flash state is IDLE.
- Stage 0 (cycle 0), geometry counters:
  - col_off/cell_x are loaded with 0 on the cycle column==BOARD_X; otherwise col_off increments and wraps at CELL-1, and cell_x increments on the wrap.
  - row_off/cell_y update only on column==0: load 0 when row==BOARD_Y, else the same increment/wrap rule.
  - in_board = column in [BOARD_X, BOARD_X+COLS*CELL) and row in [BOARD_Y, BOARD_Y+ROWS*CELL).
- Stage 1 (cycle 1):
  - Register in_board, cell_x, cell_y, col_off==0, blank_n.
  - ram_rd_en = registered in_board; ram_x/ram_y = registered cell coordinates.
  - Outside the board, ram_rd_en=0 and ram_x/ram_y hold their last value.
- Stage 2 (cycle 2): ram_color is valid. Colour priority for in_board pixels:
  1. q==FALLING and the cell matches any piece_cells entry -> piece_color.
  2. q==DISTROY_LINE, clear_mask[cell_y]=1 and flash phase ON -> white (all ones).
  3. ram_color != 0 -> ram_color.
  4. grid column (col_off==0, cell_x≠0) -> ROSE2 = {255,190,240}.
  5. otherwise -> ROSE = {255,204,229}.
  - Palette constants are 8-bit; for CW≠8 they are taken MSB-aligned (truncate or zero-pad LSBs).
  - Non-board pixels -> DARK_GREY {96,96,96}.
  - COUNTING digits are outside scope; that state renders the empty board.
- Stage 3: red/green/blue registered. They are forced to 0 when the delayed blank is 0.
- Latency: exactly 3 clocks from row/column/blank_n to outputs. Throughput is one pixel per clock, with no stalls.
- Flash FSM states:
  - IDLE -> ON when q becomes DISTROY_LINE; frame_cnt=0, blink_cnt=0.
  - ON -> OFF after FLASH_FRAMES frame_start pulses.
  - OFF -> ON after FLASH_FRAMES pulses, with blink_cnt+1.
  - When blink_cnt reaches FLASH_BLINKS on the OFF->ON edge -> DONE instead of ON.
  - DONE: flash_done pulses for one cycle, then the FSM waits in DONE until q≠DISTROY_LINE, then -> IDLE.
- q leaving DISTROY_LINE in any state -> IDLE next cycle, with no flash_done.
- frame_start coincident with a q change: the q change wins.
- Phase changes take effect only at frame_start, so no mid-frame tearing.
- reset asserted mid-frame: outputs are 0 on the next cycle. After reset, the geometry is self-correct from the next column==0/BOARD_X events.

Test Plan:
- Reset for 2 cycles with blank_n=1 -> red/green/blue=0, blank_n_o=0, flash_done=0.
- Raster at row=40, column=220..239, ram_color=0, q=FALLING, no piece hit:
  - column 220 -> ROSE at cycle +3.
  - column 240 -> ROSE2 at cycle +3.
  - column 240 -> ram_rd_en=1 with ram_x=1, ram_y=0 at cycle +1.
- RAM model returns {10,20,30} for cell (3,5); pixel column 280, row 140 -> output {10,20,30} exactly 3 cycles after input.
- q=FALLING, piece cell (3,5), piece_color {1,2,3} -> {1,2,3} overrides RAM.
- q=DISTROY_LINE, clear_mask bit 5 set, 48 frame_start pulses with default params:
  - row-5 pixels: white for frames 0-7, RAM colour for frames 8-15, repeating.
  - flash_done is exactly one pulse after frame 48.
  - rows not in the mask are unaffected.
- blank_n=0 at an in-board pixel -> outputs 0.
- q dropping to FALLING mid-flash -> no flash_done, FSM in IDLE.
